padbid_bus_reader: RTL

Read-side controller for a shared bidirectional bus built from PADBID pads.
- Parks the bus by driving a fixed value while idle.
- On request, releases the pads (OEN high) and waits out the bus turnaround.
- Samples the pad C outputs through a synchronizer and returns the word over a valid/ready response channel.
- Sits between the PADBID ring and core logic that reads external tri-state drivers.

---
 rtl/padbid_bus_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/padbid_bus_reader.sv
// padbid_bus_reader: parks a PADBID bus, releases it on request, samples pad_c through a synchronizer and returns the word; `PADBUS_STABLE_CHECK_EN adds a double-sample stability flag
module padbid_bus_reader #(
  parameter int WIDTH = 4,
  parameter int TA_CYCLES = 2,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] PARK = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] pad_oen,
  output logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] pad_c,
`ifdef PADBUS_STABLE_CHECK_EN
  output logic             rsp_unstable,
`endif
  output logic             busy
);
  localparam int MX = TA_CYCLES > SYNC_STAGES ? TA_CYCLES : SYNC_STAGES;
  localparam int CW = $clog2(MX) + 1;
`ifdef PADBUS_STABLE_CHECK_EN
  localparam int SYNC_LEN = SYNC_STAGES + 1;
`else
  localparam int SYNC_LEN = SYNC_STAGES;
`endif
  localparam logic [CW-1:0] TA_LAST = CW'(TA_CYCLES - 1);
  localparam logic [CW-1:0] SY_LAST = CW'(SYNC_LEN - 1);
  typedef enum logic [2:0] {IDLE, ACQ, SYNC, RESP, REL} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic oen;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_out;
  logic capture;
  assign sync_out = sync[SYNC_STAGES-1];
  assign capture = state == SYNC && cnt == SY_LAST;
  assign pad_oen = {WIDTH{oen}};
  assign pad_i = PARK;
  // next state and handshake outputs; any stray encoding falls back to a safe release
  always_comb begin
    next = state;
    req_ready = state == IDLE;
    busy = state != IDLE;
    case (state)
      IDLE: next = req_valid ? ACQ : IDLE;
      ACQ:  next = cnt == TA_LAST ? SYNC : ACQ;
      SYNC: next = cnt == SY_LAST ? RESP : SYNC;
      RESP: next = rsp_ready ? REL : RESP;
      REL:  next = cnt == TA_LAST ? IDLE : REL;
      default: next = REL;
    endcase
  end
  // state, per-state counter and registered (glitch-free) output enable; reset releases the pads
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= REL;
      cnt <= '0;
      oen <= 1'b1;
    end else begin
      state <= next;
      cnt <= next != state ? '0 : cnt + 1'b1;
      oen <= next != IDLE;
    end
  end
  // free-running synchronizer on the asynchronous pad outputs
  always_ff @(posedge CK or posedge RST) begin
    if (RST) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pad_c};
  end
`ifdef PADBUS_STABLE_CHECK_EN
  localparam logic [CW-1:0] SY_PREV = CW'(SYNC_LEN - 2);
  logic [WIDTH-1:0] first;
  // first of the two capture samples, compared against the second at the final SYNC edge
  always_ff @(posedge CK or posedge RST) begin
    if (RST) first <= '0;
    else if (state == SYNC && cnt == SY_PREV) first <= sync_out;
  end
  // stability flag lives and dies with rsp_valid
  always_ff @(posedge CK or posedge RST) begin
    if (RST) rsp_unstable <= 1'b0;
    else if (capture) rsp_unstable <= sync_out != first;
    else if (state == RESP && rsp_ready) rsp_unstable <= 1'b0;
  end
`endif
  // response register: loaded only at the end of SYNC, cleared by the consumer handshake
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data <= sync_out;
    end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
  end
endmodule
